fifo_sync_prog: RTL and testbench

FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

---
 rtl/fifo_sync_prog.sv | 128 ++++++++++++
 tb/tb_fifo_sync_prog.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with registered read data, programmable almost-full/almost-empty levels
// and optional sticky overflow/underflow flags (enabled by defining FIFO_ERR_FLAGS_EN).
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  wr_acc, rd_acc;

  // Flags come straight from the registered count, so a read at empty or a
  // write at full is simply never accepted; that also settles the both-at-once cases.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);
  assign count        = count_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;

  assign wr_acc = write_en && !full;
  assign rd_acc = read_en && !empty;

  // NOTE: storage has no reset; stale words are unreachable once the pointers and count clear.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  // NOTE: every variable gets a default first so this block never infers a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A new error event wins over a clear arriving in the same cycle.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write_en && full)  overflow_d  = 1'b1;
    if (read_en  && empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: a queue-based reference model predicts data,
// count, flags and error bits each cycle; a vector table plus directed corner sequences drive it.
module tb_fifo_sync_prog;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       write_en, read_en, err_clr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid, empty, full, almost_empty, almost_full;
  logic [4:0] count;
  logic       overflow, underflow;

  fifo_sync_prog dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_en     (write_en),
    .read_en      (read_en),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  int         m_count = 0;
  logic [7:0] m_dout  = 8'h00;
  logic       m_ov    = 1'b0;
  logic       m_un    = 1'b0;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [4:0] exp_count;
    logic       exp_valid;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count",        count,        m_count);
    check("empty",        empty,        m_count == 0);
    check("full",         full,         m_count == 16);
    check("almost_empty", almost_empty, m_count <= 2);
    check("almost_full",  almost_full,  m_count >= 12);
    check("data_out",     data_out,     m_dout);
    check("overflow",     overflow,     m_ov);
    check("underflow",    underflow,    m_un);
  endtask

  // One clock cycle: predict from the model, drive, clock, then compare #1 after the edge.
  task automatic step(input logic we, input logic re, input logic [7:0] din);
    logic acc_w, acc_r;
    write_en = we;
    read_en  = re;
    data_in  = din;
    acc_w = we && (m_count < 16);
    acc_r = re && (m_count > 0);
`ifdef FIFO_ERR_FLAGS_EN
    if (err_clr) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end
    if (we && m_count == 16) m_ov = 1'b1;
    if (re && m_count == 0)  m_un = 1'b1;
`endif
    if (acc_r) m_dout = sb.pop_front();
    if (acc_w) sb.push_back(din);
    m_count = m_count + (acc_w ? 1 : 0) - (acc_r ? 1 : 0);
    @(posedge clk);
    #1;
    check("data_valid", data_valid, acc_r);
    check_state();
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{we:1'b0, re:1'b1, din:8'h00, exp_count:5'd0, exp_valid:1'b0};
    vecs[1] = '{we:1'b1, re:1'b0, din:8'h11, exp_count:5'd1, exp_valid:1'b0};
    vecs[2] = '{we:1'b1, re:1'b0, din:8'h22, exp_count:5'd2, exp_valid:1'b0};
    vecs[3] = '{we:1'b1, re:1'b1, din:8'h33, exp_count:5'd2, exp_valid:1'b1};
    vecs[4] = '{we:1'b0, re:1'b1, din:8'h00, exp_count:5'd1, exp_valid:1'b1};
    vecs[5] = '{we:1'b0, re:1'b1, din:8'h00, exp_count:5'd0, exp_valid:1'b1};
    vecs[6] = '{we:1'b0, re:1'b1, din:8'h00, exp_count:5'd0, exp_valid:1'b0};
    vecs[7] = '{we:1'b1, re:1'b1, din:8'h44, exp_count:5'd1, exp_valid:1'b0};
    vecs[8] = '{we:1'b0, re:1'b1, din:8'h00, exp_count:5'd0, exp_valid:1'b1};

    reset_n  = 1'b0;
    write_en = 1'b0;
    read_en  = 1'b0;
    err_clr  = 1'b0;
    data_in  = 8'h00;

    // Reset state, both during reset and after the first edge out of it
    #12;
    check("rst_valid", data_valid, 1'b0);
    check_state();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", data_valid, 1'b0);
    check_state();

    // Vector table: accesses at empty, both-at-once at 0 and mid-level
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].we, vecs[i].re, vecs[i].din);
      check($sformatf("tbl%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("tbl%0d_valid", i), data_valid, vecs[i].exp_valid);
    end

    // Error flags clear when err_clr is pulsed
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;

    // Fill with 0x00..0x0F, threshold at 11/12
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 10) check("af_at_11", almost_full, 1'b0);
      if (i == 11) check("af_at_12", almost_full, 1'b1);
    end
    check("fill_full", full, 1'b1);
    check("fill_count", count, 5'd16);

    // Write at full is dropped; sets overflow when error flags are built in
    step(1'b1, 1'b0, 8'hFF);

    // Drain and confirm write order, threshold at 3/2
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("drain_data", data_out, i);
      if (i == 12) check("ae_at_3", almost_empty, 1'b0);
      if (i == 13) check("ae_at_2", almost_empty, 1'b1);
    end
    check("drain_empty", empty, 1'b1);

    // Read at empty: no valid data, underflow set when built in
    step(1'b0, 1'b1, 8'h00);

    // Clear coinciding with a new error: the new error wins
    err_clr = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    err_clr = 1'b0;
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;

    // Simultaneous access at full acts as a read only
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h80 + 8'(i));
    step(1'b1, 1'b1, 8'hEE);
    check("full_both_count", count, 5'd15);
    check("full_both_data", data_out, 8'h80);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);

    // Steady state at count=5 for 20 cycles, pointers wrap
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'h50 + 8'(i));
      check("steady_count", count, 5'd5);
    end

    // Asynchronous reset mid-operation at count=9
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h70 + 8'(i));
    check("pre_rst_count", count, 5'd9);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    m_count = 0;
    m_dout  = 8'h00;
    m_ov    = 1'b0;
    m_un    = 1'b0;
    check("async_rst_valid", data_valid, 1'b0);
    check_state();
    #2;
    reset_n = 1'b1;
    step(1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_data", data_out, 8'hA5);
    check("post_rst_empty", empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
